cache_arbiter: RTL and testbench
================================

CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 The module SHALL have parameter LINE_W, default 256, meaning the cacheline width in bits.
REQ-002 The module SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-low reset, sampled on the clk rising edge.
REQ-005 The module SHALL have port i_read, input, 1 bit: icache line-fill request.
REQ-006 The module SHALL have port i_address, input, ADDR_W bits: icache line address.
REQ-007 The module SHALL have port i_rdata, output, LINE_W bits: line returned to icache.
REQ-008 The module SHALL have port i_resp, output, 1 bit: icache transaction done.
REQ-009 The module SHALL have port d_read, input, 1 bit: dcache line-fill request.
REQ-010 The module SHALL have port d_write, input, 1 bit: dcache writeback request.
REQ-011 The module SHALL have port d_address, input, ADDR_W bits: dcache line address.
REQ-012 The module SHALL have port d_wdata, input, LINE_W bits: dcache writeback line.
REQ-013 The module SHALL have port d_rdata, output, LINE_W bits: line returned to dcache.
REQ-014 The module SHALL have port d_resp, output, 1 bit: dcache transaction done.
REQ-015 The module SHALL have port address_o, output, ADDR_W bits: address to the cacheline adaptor.
REQ-016 The module SHALL have port read_o, output, 1 bit: line read to the adaptor.
REQ-017 The module SHALL have port write_o, output, 1 bit: line write to the adaptor.
REQ-018 The module SHALL have port burst_o, output, LINE_W bits: write line to the adaptor.
REQ-019 The module SHALL have port burst_i, input, LINE_W bits: read line from the adaptor.
REQ-020 The module SHALL have port resp_i, input, 1 bit: adaptor transaction done.

Function
REQ-021 The FSM SHALL have exactly four states: IDLE, SERVE_I, SERVE_D, RESP.
REQ-022 In IDLE, with only the icache pending, the FSM SHALL latch i_address and go to SERVE_I next cycle.
REQ-023 In IDLE, with only the dcache pending (d_read or d_write), the FSM SHALL latch d_address, d_wdata and op type, and go to SERVE_D.
REQ-024 When both caches are pending in IDLE, the grant SHALL go to the side opposite the last conflict winner (1-bit last_grant flag, reset value = icache, so dcache wins the first conflict).
REQ-025 last_grant SHALL update only on conflicts, never on uncontested grants.
REQ-026 If d_read and d_write are both high, the op SHALL be treated as a write.
REQ-027 In SERVE_I/SERVE_D, read_o or write_o SHALL be held high with address_o and burst_o driven from latched values, stable until resp_i.
REQ-028 On resp_i in SERVE_x, burst_i SHALL be latched into the return register, read_o/write_o SHALL drop the next cycle, and the FSM SHALL move to RESP.
REQ-029 In RESP, exactly one of i_resp/d_resp SHALL be high for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-030 i_rdata/d_rdata SHALL present the latched line while resp is high.
REQ-031 A request SHALL be eligible for a new grant only in IDLE, so a client holding its request one cycle past resp is not re-served.
REQ-032 resp_i outside SERVE_x SHALL be ignored.
REQ-033 Minimum latency SHALL be 1 cycle (request to read_o/write_o), plus adaptor time, plus 2 cycles (resp_i to client resp).
REQ-034 Input request changes during SERVE_x SHALL not alter the outstanding transaction.

Reset
REQ-035 While rst=0 at a clk edge, the FSM SHALL go to IDLE and last_grant SHALL reset to icache.
REQ-036 While rst=0, read_o, write_o, i_resp and d_resp SHALL be 0, and address_o, burst_o, i_rdata and d_rdata SHALL be 0.
REQ-037 Reset mid-transaction SHALL abandon the transaction with no client resp issued.

Structure
REQ-038 Package arbiter_pkg SHALL hold the arb_state_t enum (IDLE, SERVE_I, SERVE_D, RESP), the grant_t enum (GRANT_I, GRANT_D) and the LINE_W/ADDR_W defaults.
REQ-039 The design SHALL be a single module with no sub-modules.
REQ-040 The FSM SHALL have a registered next-state, and all outputs SHALL be driven from registers.

Verification
REQ-041 Icache-only: i_read, i_address=0x0000_0060, adaptor resp after 4 cycles with burst_i=all A5 bytes -> read_o 1 cycle after request; i_resp one cycle; i_rdata=A5..A5; no d_resp.
REQ-042 Dcache writeback: d_write, d_address=0x0000_1000, d_wdata=0xDEAD...BEEF -> write_o=1, burst_o=d_wdata, read_o=0; d_resp one cycle.
REQ-043 Conflict alternation: both requesting continuously for 4 transactions -> grant order D, I, D, I.
REQ-044 Hold-after-resp: client keeps i_read high for one cycle after i_resp -> no second read_o.
REQ-045 Mid-transaction reset: rst=0 while read_o=1 in SERVE_D -> next cycle read_o=0, FSM in IDLE, d_resp never asserted.
REQ-046 Stray resp_i in IDLE -> no client resp, FSM remains IDLE.

Source files
------------

// File: rtl/arbiter_pkg.sv
// Shared types and width defaults for the icache/dcache to cacheline-adaptor arbiter.
// Holds no logic.
package arbiter_pkg;

  localparam int LINE_W_DEFAULT = 256;
  localparam int ADDR_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Arbitrates icache fills and dcache fills/writebacks onto one cacheline adaptor.
// Latency: 1 cycle request->read_o/write_o, adaptor time, then 2 cycles resp_i->client resp.
// Backpressure: clients hold requests until their resp; new grants are made only in IDLE.
module cache_arbiter
  import arbiter_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic [ADDR_W-1:0] address_o,
  output logic              read_o,
  output logic              write_o,
  output logic [LINE_W-1:0] burst_o,
  input  logic [LINE_W-1:0] burst_i,
  input  logic              resp_i
);

  arb_state_t state;
  grant_t     last_grant;
  logic       serving_d;
  logic       d_pend;
  logic       conflict;
  logic       grant_d;

  // On a conflict the side that did not win the previous conflict is served.
  always_comb begin
    d_pend   = d_read | d_write;
    conflict = i_read & d_pend;
    grant_d  = d_pend & (~i_read | (last_grant == GRANT_I));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      serving_d  <= 1'b0;
      address_o  <= '0;
      burst_o    <= '0;
      read_o     <= 1'b0;
      write_o    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_resp     <= 1'b0;
      d_resp     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read | d_pend) begin
            if (conflict) last_grant <= grant_d ? GRANT_D : GRANT_I;
            serving_d <= grant_d;
            if (grant_d) begin
              state     <= SERVE_D;
              address_o <= d_address;
              burst_o   <= d_wdata;
              write_o   <= d_write;
              read_o    <= ~d_write;
            end else begin
              state     <= SERVE_I;
              address_o <= i_address;
              burst_o   <= '0;
              read_o    <= 1'b1;
            end
          end
        end
        SERVE_I: begin
          if (resp_i) begin
            i_rdata <= burst_i;
            read_o  <= 1'b0;
            state   <= RESP;
          end
        end
        SERVE_D: begin
          if (resp_i) begin
            d_rdata <= burst_i;
            read_o  <= 1'b0;
            write_o <= 1'b0;
            state   <= RESP;
          end
        end
        RESP: begin
          // First RESP cycle raises the client resp; the second drops it. Staying
          // out of IDLE while resp is visible keeps a lingering request from being re-granted.
          if (i_resp | d_resp) begin
            i_resp <= 1'b0;
            d_resp <= 1'b0;
            state  <= IDLE;
          end else begin
            i_resp <= ~serving_d;
            d_resp <= serving_d;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed self-checking bench for cache_arbiter.
module tb_cache_arbiter;
  import arbiter_pkg::*;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_address;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_address;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic [AW-1:0] address_o;
  logic          read_o;
  logic          write_o;
  logic [LW-1:0] burst_o;
  logic [LW-1:0] burst_i;
  logic          resp_i;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cache_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .address_o(address_o), .read_o(read_o), .write_o(write_o), .burst_o(burst_o),
    .burst_i(burst_i), .resp_i(resp_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the adaptor command; returns cycles taken, or -1 if it never came.
  task automatic wait_cmd(output int cyc);
    cyc = -1;
    for (int n = 0; n < 8; n++) begin
      tick();
      if (read_o || write_o) begin
        cyc = n + 1;
        return;
      end
    end
  endtask

  // Pulses resp_i for one edge, then advances to the cycle where client resp shows.
  task automatic adaptor_respond(input logic [LW-1:0] data);
    burst_i = data;
    resp_i  = 1'b1;
    tick();
    resp_i  = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if ({read_o, write_o, i_resp, d_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000", {read_o, write_o, i_resp, d_resp});
    end
    checks++;
    if (address_o !== '0 || burst_o !== '0 || i_rdata !== '0 || d_rdata !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h burst/rdata nonzero, want all 0", address_o);
    end
    checks++;
    if (dut.state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d want IDLE", dut.state);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_icache_only();
    int cyc;
    i_read    = 1'b1;
    i_address = 32'h0000_0060;
    wait_cmd(cyc);
    i_read    = 1'b0;
    checks++;
    if (cyc !== 1 || read_o !== 1'b1 || write_o !== 1'b0 || address_o !== 32'h60) begin
      errors++;
      $display("FAIL icache_cmd: cyc=%0d rd=%b wr=%b addr=%h want 1 1 0 00000060",
               cyc, read_o, write_o, address_o);
    end
    tick();
    tick();
    tick();
    checks++;
    if (read_o !== 1'b1 || address_o !== 32'h60) begin
      errors++;
      $display("FAIL icache_hold: rd=%b addr=%h want 1 00000060", read_o, address_o);
    end
    burst_i = {32{8'hA5}};
    resp_i  = 1'b1;
    tick();
    resp_i  = 1'b0;
    checks++;
    if (read_o !== 1'b0 || i_resp !== 1'b0) begin
      errors++;
      $display("FAIL icache_drop: rd=%b i_resp=%b want 0 0", read_o, i_resp);
    end
    tick();
    checks++;
    if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== {32{8'hA5}}) begin
      errors++;
      $display("FAIL icache_resp: i_resp=%b d_resp=%b i_rdata=%h want 1 0 A5..A5",
               i_resp, d_resp, i_rdata);
    end
    tick();
    checks++;
    if (i_resp !== 1'b0 || d_resp !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL icache_resp_end: i_resp=%b d_resp=%b state=%0d want 0 0 IDLE",
               i_resp, d_resp, dut.state);
    end
  endtask

  task automatic test_dcache_write();
    int cyc;
    logic [LW-1:0] wline;
    wline     = {8{32'hDEAD_BEEF}};
    d_write   = 1'b1;
    d_address = 32'h0000_1000;
    d_wdata   = wline;
    wait_cmd(cyc);
    d_write   = 1'b0;
    d_wdata   = '0;
    checks++;
    if (cyc !== 1 || write_o !== 1'b1 || read_o !== 1'b0 ||
        address_o !== 32'h1000 || burst_o !== wline) begin
      errors++;
      $display("FAIL dwrite_cmd: cyc=%0d wr=%b rd=%b addr=%h burst_ok=%b want 1 1 0 00001000 1",
               cyc, write_o, read_o, address_o, burst_o === wline);
    end
    tick();
    adaptor_respond('0);
    checks++;
    if (d_resp !== 1'b1 || i_resp !== 1'b0 || write_o !== 1'b0) begin
      errors++;
      $display("FAIL dwrite_resp: d_resp=%b i_resp=%b wr=%b want 1 0 0", d_resp, i_resp, write_o);
    end
    tick();
    // Read and write together must be issued as a write.
    d_read    = 1'b1;
    d_write   = 1'b1;
    d_address = 32'h0000_2000;
    d_wdata   = ~wline;
    wait_cmd(cyc);
    d_read    = 1'b0;
    d_write   = 1'b0;
    checks++;
    if (write_o !== 1'b1 || read_o !== 1'b0 || burst_o !== ~wline) begin
      errors++;
      $display("FAIL dboth_is_write: wr=%b rd=%b want 1 0", write_o, read_o);
    end
    adaptor_respond('0);
    checks++;
    if (d_resp !== 1'b1) begin
      errors++;
      $display("FAIL dboth_resp: d_resp=%b want 1", d_resp);
    end
    tick();
  endtask

  task automatic test_alternation();
    int cyc;
    logic exp_d [4];
    exp_d     = '{1'b1, 1'b0, 1'b1, 1'b0};
    i_address = 32'h0000_0100;
    d_address = 32'h0000_0200;
    i_read    = 1'b1;
    d_read    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_cmd(cyc);
      checks++;
      if (cyc !== 1 || address_o !== (exp_d[k] ? 32'h200 : 32'h100)) begin
        errors++;
        $display("FAIL alt_grant%0d: cyc=%0d addr=%h want 1 %h", k, cyc, address_o,
                 exp_d[k] ? 32'h200 : 32'h100);
      end
      adaptor_respond({8{32'(k + 1)}});
      checks++;
      if (d_resp !== exp_d[k] || i_resp !== ~exp_d[k]) begin
        errors++;
        $display("FAIL alt_resp%0d: d_resp=%b i_resp=%b want %b %b", k, d_resp, i_resp,
                 exp_d[k], ~exp_d[k]);
      end
      if (k == 3) begin
        i_read = 1'b0;
        d_read = 1'b0;
      end
      tick();
    end
    // An uncontested dcache grant must not move the conflict pointer.
    d_read    = 1'b1;
    wait_cmd(cyc);
    d_read    = 1'b0;
    adaptor_respond('0);
    tick();
    i_read    = 1'b1;
    d_read    = 1'b1;
    wait_cmd(cyc);
    i_read    = 1'b0;
    d_read    = 1'b0;
    checks++;
    if (address_o !== 32'h200) begin
      errors++;
      $display("FAIL uncontested_keeps_pointer: addr=%h want 00000200", address_o);
    end
    adaptor_respond('0);
    tick();
  endtask

  task automatic test_hold_after_resp();
    int cyc;
    int extra;
    i_read    = 1'b1;
    i_address = 32'h0000_0040;
    wait_cmd(cyc);
    adaptor_respond({32{8'h3C}});
    checks++;
    if (i_resp !== 1'b1 || i_rdata !== {32{8'h3C}}) begin
      errors++;
      $display("FAIL hold_resp: i_resp=%b i_rdata=%h want 1 3C..3C", i_resp, i_rdata);
    end
    tick();
    i_read = 1'b0;
    extra  = 0;
    for (int n = 0; n < 4; n++) begin
      if (read_o) extra++;
      tick();
    end
    checks++;
    if (extra !== 0) begin
      errors++;
      $display("FAIL hold_no_reissue: read_o cycles=%0d want 0", extra);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    int resps;
    d_read    = 1'b1;
    d_address = 32'h0000_0300;
    wait_cmd(cyc);
    d_read    = 1'b0;
    checks++;
    if (read_o !== 1'b1 || dut.state !== SERVE_D) begin
      errors++;
      $display("FAIL midrst_pre: rd=%b state=%0d want 1 SERVE_D", read_o, dut.state);
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    checks++;
    if (read_o !== 1'b0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL midrst_abort: rd=%b state=%0d want 0 IDLE", read_o, dut.state);
    end
    resps = 0;
    for (int n = 0; n < 5; n++) begin
      if (d_resp || i_resp) resps++;
      tick();
    end
    checks++;
    if (resps !== 0) begin
      errors++;
      $display("FAIL midrst_no_resp: resp cycles=%0d want 0", resps);
    end
  endtask

  task automatic test_stray_resp();
    int resps;
    burst_i = {32{8'hFF}};
    resp_i  = 1'b1;
    tick();
    resp_i  = 1'b0;
    resps   = 0;
    for (int n = 0; n < 3; n++) begin
      if (d_resp || i_resp || read_o || write_o) resps++;
      tick();
    end
    checks++;
    if (resps !== 0 || dut.state !== IDLE) begin
      errors++;
      $display("FAIL stray_resp: active cycles=%0d state=%0d want 0 IDLE", resps, dut.state);
    end
  endtask

  initial begin
    rst       = 1'b0;
    i_read    = 1'b0;
    i_address = '0;
    d_read    = 1'b0;
    d_write   = 1'b0;
    d_address = '0;
    d_wdata   = '0;
    burst_i   = '0;
    resp_i    = 1'b0;
    test_reset();
    test_icache_only();
    test_dcache_write();
    test_alternation();
    test_hold_after_resp();
    test_mid_reset();
    test_stray_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
